// File: rtl/user_logic_c0_pkg.sv
// Shared types and constants for the c0 user-logic region.
// Holds the descriptor/completion/interrupt record layouts, the host stream encoding,
// the CSR index map and a byte-strobe merge helper used by the register file.
package user_logic_c0_pkg;

  localparam int unsigned VaddrBits    = 48;
  localparam int unsigned LenBits      = 28;
  localparam int unsigned PidBits      = 6;
  localparam int unsigned DestBits     = 4;
  localparam int unsigned CsrDataBits  = 64;
  localparam int unsigned AxilAddrBits = 16;

  localparam logic [1:0] StrmCard = 2'd0;
  localparam logic [1:0] StrmHost = 2'd1;

  // CSR index = address[5:3]
  localparam logic [2:0] CsrCtrl    = 3'd0;
  localparam logic [2:0] CsrStatus  = 3'd1;
  localparam logic [2:0] CsrRdVaddr = 3'd2;
  localparam logic [2:0] CsrWrVaddr = 3'd3;
  localparam logic [2:0] CsrLen     = 3'd4;
  localparam logic [2:0] CsrPid     = 3'd5;
  localparam logic [2:0] CsrBeats   = 3'd6;
  localparam logic [2:0] CsrAddc    = 3'd7;

  typedef struct packed {
    logic [VaddrBits-1:0] vaddr;
    logic [LenBits-1:0]   len;
    logic [1:0]           strm;
    logic [DestBits-1:0]  dest;
    logic [PidBits-1:0]   pid;
    logic                 last;
  } req_t;

  typedef struct packed {
    logic [PidBits-1:0]  pid;
    logic [DestBits-1:0] dest;
    logic [1:0]          strm;
  } ack_t;

  typedef struct packed {
    logic [PidBits-1:0] pid;
    logic [31:0]        value;
  } irq_not_t;

  // Replace only the bytes enabled in strb.
  function automatic logic [CsrDataBits-1:0] strb_merge(
    input logic [CsrDataBits-1:0]   old_val,
    input logic [CsrDataBits-1:0]   wdata,
    input logic [CsrDataBits/8-1:0] strb
  );
    logic [CsrDataBits-1:0] res;
    res = old_val;
    for (int b = 0; b < CsrDataBits / 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_csr_slave.sv
// AXI-Lite register file for the c0 transfer engine.
// Ports: aclk/aresetn (sync active-low); AXI-Lite aw/w/b/ar/r channels; register outputs
// rd_vaddr, wr_vaddr, len, pid, addc; one-cycle start and clear pulses from CTRL writes;
// status inputs busy, done, err and the beat counter.
module user_csr_slave
  import user_logic_c0_pkg::*;
(
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AxilAddrBits-1:0]   awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [CsrDataBits-1:0]    wdata,
  input  logic [CsrDataBits/8-1:0]  wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [AxilAddrBits-1:0]   araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [CsrDataBits-1:0]    rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [VaddrBits-1:0]      rd_vaddr,
  output logic [VaddrBits-1:0]      wr_vaddr,
  output logic [LenBits-1:0]        len,
  output logic [PidBits-1:0]        pid,
  output logic [31:0]               addc,
  output logic                      start,
  output logic                      clear,
  input  logic                      busy,
  input  logic                      done,
  input  logic                      err,
  input  logic [63:0]               beats
);

  logic [VaddrBits-1:0]   rd_vaddr_q, wr_vaddr_q;
  logic [LenBits-1:0]     len_q;
  logic [PidBits-1:0]     pid_q;
  logic [31:0]            addc_q;
  logic                   bvalid_q, rvalid_q;
  logic [CsrDataBits-1:0] rdata_q;
  logic [CsrDataBits-1:0] rd_word;
  logic                   wr_hs, rd_hs, wr_hit, rd_hit;
  logic [2:0]             wr_idx, rd_idx;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[2:0], araddr[2:0]};

  // Address and data are accepted together, and only with no response outstanding.
  assign awready = aresetn & awvalid & wvalid & ~bvalid_q;
  assign wready  = awready;
  assign wr_hs   = awready;
  assign arready = aresetn & ~rvalid_q;
  assign rd_hs   = arvalid & arready;

  // Anything above 0x38 is unmapped rather than aliased.
  assign wr_hit = (awaddr[AxilAddrBits-1:6] == '0);
  assign rd_hit = (araddr[AxilAddrBits-1:6] == '0);
  assign wr_idx = awaddr[5:3];
  assign rd_idx = araddr[5:3];

  assign start = wr_hs & wr_hit & (wr_idx == CsrCtrl) & wstrb[0] & wdata[0];
  assign clear = wr_hs & wr_hit & (wr_idx == CsrCtrl) & wstrb[0] & wdata[1];

  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      unique case (rd_idx)
        CsrStatus:  rd_word = {61'd0, err, done, busy};
        CsrRdVaddr: rd_word = 64'(rd_vaddr_q);
        CsrWrVaddr: rd_word = 64'(wr_vaddr_q);
        CsrLen:     rd_word = 64'(len_q);
        CsrPid:     rd_word = 64'(pid_q);
        CsrBeats:   rd_word = beats;
        CsrAddc:    rd_word = 64'(addc_q);
        default:    rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_vaddr_q <= '0;
      wr_vaddr_q <= '0;
      len_q      <= '0;
      pid_q      <= '0;
      addc_q     <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (wr_hs) begin
        bvalid_q <= 1'b1;
      end else if (bready) begin
        bvalid_q <= 1'b0;
      end

      if (wr_hs && wr_hit) begin
        unique case (wr_idx)
          CsrRdVaddr: rd_vaddr_q <= VaddrBits'(strb_merge(64'(rd_vaddr_q), wdata, wstrb));
          CsrWrVaddr: wr_vaddr_q <= VaddrBits'(strb_merge(64'(wr_vaddr_q), wdata, wstrb));
          CsrLen:     len_q      <= LenBits'(strb_merge(64'(len_q), wdata, wstrb));
          CsrPid:     pid_q      <= PidBits'(strb_merge(64'(pid_q), wdata, wstrb));
          CsrAddc:    addc_q     <= 32'(strb_merge(64'(addc_q), wdata, wstrb));
          default:    ;
        endcase
      end

      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bvalid   = bvalid_q;
  assign bresp    = 2'b00;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = 2'b00;
  assign rd_vaddr = rd_vaddr_q;
  assign wr_vaddr = wr_vaddr_q;
  assign len      = len_q;
  assign pid      = pid_q;
  assign addc     = addc_q;

endmodule

// File: rtl/user_logic_c0.sv
// vFPGA user-logic region c0: CSR-programmed host-stream transfer engine.
// Ports: aclk/aresetn (sync active-low); axi_ctrl_* AXI-Lite CSR slave; notify_* completion
// interrupt; sq_rd_*/sq_wr_* descriptor requests; cq_rd_*/cq_wr_* completions;
// axis_host_recv_*/axis_host_send_* host streams (only stream 0 is active).
// Per job: issue one read and one write descriptor, forward recv data to send with ADDC added
// to every 32-bit lane, wait for both completions, then raise notify {pid, beats}.
module user_logic_c0
  import user_logic_c0_pkg::*;
#(
  parameter int unsigned N_STRM_AXI    = 1,
  parameter int unsigned AXI_DATA_BITS = 512,
  parameter int unsigned CSR_DATA_BITS = 64  // register file is built for 64 only
) (
  input  logic                                          aclk,
  input  logic                                          aresetn,
  input  logic [AxilAddrBits-1:0]                       axi_ctrl_awaddr,
  input  logic                                          axi_ctrl_awvalid,
  output logic                                          axi_ctrl_awready,
  input  logic [CSR_DATA_BITS-1:0]                      axi_ctrl_wdata,
  input  logic [CSR_DATA_BITS/8-1:0]                    axi_ctrl_wstrb,
  input  logic                                          axi_ctrl_wvalid,
  output logic                                          axi_ctrl_wready,
  output logic [1:0]                                    axi_ctrl_bresp,
  output logic                                          axi_ctrl_bvalid,
  input  logic                                          axi_ctrl_bready,
  input  logic [AxilAddrBits-1:0]                       axi_ctrl_araddr,
  input  logic                                          axi_ctrl_arvalid,
  output logic                                          axi_ctrl_arready,
  output logic [CSR_DATA_BITS-1:0]                      axi_ctrl_rdata,
  output logic [1:0]                                    axi_ctrl_rresp,
  output logic                                          axi_ctrl_rvalid,
  input  logic                                          axi_ctrl_rready,
  output logic                                          notify_valid,
  input  logic                                          notify_ready,
  output irq_not_t                                      notify_data,
  output logic                                          sq_rd_valid,
  input  logic                                          sq_rd_ready,
  output req_t                                          sq_rd_data,
  output logic                                          sq_wr_valid,
  input  logic                                          sq_wr_ready,
  output req_t                                          sq_wr_data,
  input  logic                                          cq_rd_valid,
  output logic                                          cq_rd_ready,
  input  ack_t                                          cq_rd_data,
  input  logic                                          cq_wr_valid,
  output logic                                          cq_wr_ready,
  input  ack_t                                          cq_wr_data,
  input  logic [N_STRM_AXI-1:0]                         axis_host_recv_tvalid,
  output logic [N_STRM_AXI-1:0]                         axis_host_recv_tready,
  input  logic [N_STRM_AXI-1:0][AXI_DATA_BITS-1:0]      axis_host_recv_tdata,
  input  logic [N_STRM_AXI-1:0][AXI_DATA_BITS/8-1:0]    axis_host_recv_tkeep,
  input  logic [N_STRM_AXI-1:0]                         axis_host_recv_tlast,
  input  logic [N_STRM_AXI-1:0][PidBits-1:0]            axis_host_recv_tid,
  output logic [N_STRM_AXI-1:0]                         axis_host_send_tvalid,
  input  logic [N_STRM_AXI-1:0]                         axis_host_send_tready,
  output logic [N_STRM_AXI-1:0][AXI_DATA_BITS-1:0]      axis_host_send_tdata,
  output logic [N_STRM_AXI-1:0][AXI_DATA_BITS/8-1:0]    axis_host_send_tkeep,
  output logic [N_STRM_AXI-1:0]                         axis_host_send_tlast,
  output logic [N_STRM_AXI-1:0][PidBits-1:0]            axis_host_send_tid
);

  localparam int unsigned Lanes = AXI_DATA_BITS / 32;

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StNotify} state_e;

  state_e state_q, state_d;
  logic   rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic   cq_rd_seen_q, cq_rd_seen_d, cq_wr_seen_q, cq_wr_seen_d;
  logic   done_q, done_d, err_q, err_d;
  logic   latch, busy, send_hs;
  req_t   rd_req_q, wr_req_q;
  logic [31:0] addc_q;
  logic [63:0] beats_q;

  logic [VaddrBits-1:0] csr_rd_vaddr, csr_wr_vaddr;
  logic [LenBits-1:0]   csr_len;
  logic [PidBits-1:0]   csr_pid;
  logic [31:0]          csr_addc;
  logic                 csr_start, csr_clear;
  logic                 unused_inputs;

  // Completion payloads carry nothing this engine needs.
  assign unused_inputs = ^{cq_rd_data, cq_wr_data, axis_host_recv_tdata, axis_host_recv_tkeep,
                           axis_host_recv_tlast, axis_host_recv_tid, axis_host_recv_tvalid,
                           axis_host_send_tready};

  user_csr_slave u_csr (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .awaddr   (axi_ctrl_awaddr),
    .awvalid  (axi_ctrl_awvalid),
    .awready  (axi_ctrl_awready),
    .wdata    (axi_ctrl_wdata),
    .wstrb    (axi_ctrl_wstrb),
    .wvalid   (axi_ctrl_wvalid),
    .wready   (axi_ctrl_wready),
    .bresp    (axi_ctrl_bresp),
    .bvalid   (axi_ctrl_bvalid),
    .bready   (axi_ctrl_bready),
    .araddr   (axi_ctrl_araddr),
    .arvalid  (axi_ctrl_arvalid),
    .arready  (axi_ctrl_arready),
    .rdata    (axi_ctrl_rdata),
    .rresp    (axi_ctrl_rresp),
    .rvalid   (axi_ctrl_rvalid),
    .rready   (axi_ctrl_rready),
    .rd_vaddr (csr_rd_vaddr),
    .wr_vaddr (csr_wr_vaddr),
    .len      (csr_len),
    .pid      (csr_pid),
    .addc     (csr_addc),
    .start    (csr_start),
    .clear    (csr_clear),
    .busy     (busy),
    .done     (done_q),
    .err      (err_q),
    .beats    (beats_q)
  );

  assign busy = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    rd_pend_d    = rd_pend_q;
    wr_pend_d    = wr_pend_q;
    cq_rd_seen_d = cq_rd_seen_q;
    cq_wr_seen_d = cq_wr_seen_q;
    done_d       = done_q;
    err_d        = err_q;
    latch        = 1'b0;

    if (csr_clear) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    // Completions are sticky for the whole job, whichever arrives first.
    if (busy && cq_rd_valid) cq_rd_seen_d = 1'b1;
    if (busy && cq_wr_valid) cq_wr_seen_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (csr_start) begin
          if (csr_len == '0) begin
            err_d = 1'b1;
          end else begin
            state_d      = StIssue;
            latch        = 1'b1;
            done_d       = 1'b0;
            rd_pend_d    = 1'b1;
            wr_pend_d    = 1'b1;
            cq_rd_seen_d = 1'b0;
            cq_wr_seen_d = 1'b0;
          end
        end
      end
      StIssue: begin
        if (sq_rd_ready) rd_pend_d = 1'b0;
        if (sq_wr_ready) wr_pend_d = 1'b0;
        if ((!rd_pend_q || sq_rd_ready) && (!wr_pend_q || sq_wr_ready)) state_d = StRun;
      end
      StRun: begin
        if (cq_rd_seen_d && cq_wr_seen_d) state_d = StNotify;
      end
      StNotify: begin
        if (notify_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      rd_pend_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      cq_rd_seen_q <= 1'b0;
      cq_wr_seen_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_req_q     <= '0;
      wr_req_q     <= '0;
      addc_q       <= '0;
      beats_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rd_pend_d;
      wr_pend_q    <= wr_pend_d;
      cq_rd_seen_q <= cq_rd_seen_d;
      cq_wr_seen_q <= cq_wr_seen_d;
      done_q       <= done_d;
      err_q        <= err_d;
      // Job parameters are frozen here so CSR writes during a job only affect the next one.
      if (latch) begin
        rd_req_q <= '{vaddr: csr_rd_vaddr, len: csr_len, strm: StrmHost, dest: '0,
                      pid: csr_pid, last: 1'b1};
        wr_req_q <= '{vaddr: csr_wr_vaddr, len: csr_len, strm: StrmHost, dest: '0,
                      pid: csr_pid, last: 1'b1};
        addc_q   <= csr_addc;
        beats_q  <= '0;
      end else if (send_hs) begin
        beats_q  <= beats_q + 64'd1;
      end
    end
  end

  assign sq_rd_valid = (state_q == StIssue) && rd_pend_q;
  assign sq_wr_valid = (state_q == StIssue) && wr_pend_q;
  assign sq_rd_data  = rd_req_q;
  assign sq_wr_data  = wr_req_q;
  assign cq_rd_ready = 1'b1;
  assign cq_wr_ready = 1'b1;

  assign notify_valid = (state_q == StNotify);
  assign notify_data  = '{pid: rd_req_q.pid, value: beats_q[31:0]};

  // Stream 0 datapath; payload is zeroed while idle, other streams are tied off.
  always_comb begin
    axis_host_send_tvalid = '0;
    axis_host_recv_tready = '0;
    axis_host_send_tdata  = '0;
    axis_host_send_tkeep  = '0;
    axis_host_send_tlast  = '0;
    axis_host_send_tid    = '0;
    axis_host_send_tvalid[0] = axis_host_recv_tvalid[0] & busy;
    axis_host_recv_tready[0] = axis_host_send_tready[0] & busy;
    if (busy) begin
      for (int l = 0; l < Lanes; l++) begin
        axis_host_send_tdata[0][l*32 +: 32] = axis_host_recv_tdata[0][l*32 +: 32] + addc_q;
      end
      axis_host_send_tkeep[0] = axis_host_recv_tkeep[0];
      axis_host_send_tlast[0] = axis_host_recv_tlast[0];
      axis_host_send_tid[0]   = axis_host_recv_tid[0];
    end
  end

  assign send_hs = axis_host_send_tvalid[0] & axis_host_send_tready[0];

endmodule

// File: tb/tb_user_logic_c0.sv
// Directed self-checking bench for user_logic_c0: CSR access, one full job with data
// forwarding and completion/notify, error and busy edge cases, and reset mid-job.
module tb_user_logic_c0;
  import user_logic_c0_pkg::*;

  localparam int unsigned DW = 512;
  typedef logic [DW:0] wide_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic                    aresetn;
  logic [AxilAddrBits-1:0] awaddr, araddr;
  logic                    awvalid, awready, wvalid, wready, bvalid, bready;
  logic [63:0]             wdata, rdata;
  logic [7:0]              wstrb;
  logic [1:0]              bresp, rresp;
  logic                    arvalid, arready, rvalid, rready;
  logic                    notify_valid, notify_ready;
  irq_not_t                notify_data;
  logic                    sq_rd_valid, sq_rd_ready, sq_wr_valid, sq_wr_ready;
  req_t                    sq_rd_data, sq_wr_data;
  logic                    cq_rd_valid, cq_rd_ready, cq_wr_valid, cq_wr_ready;
  ack_t                    cq_rd_data, cq_wr_data;
  logic [0:0]              recv_tvalid, recv_tready, recv_tlast;
  logic [0:0][DW-1:0]      recv_tdata;
  logic [0:0][DW/8-1:0]    recv_tkeep;
  logic [0:0][PidBits-1:0] recv_tid;
  logic [0:0]              send_tvalid, send_tready, send_tlast;
  logic [0:0][DW-1:0]      send_tdata;
  logic [0:0][DW/8-1:0]    send_tkeep;
  logic [0:0][PidBits-1:0] send_tid;

  user_logic_c0 dut (
    .aclk                  (aclk),
    .aresetn               (aresetn),
    .axi_ctrl_awaddr       (awaddr),
    .axi_ctrl_awvalid      (awvalid),
    .axi_ctrl_awready      (awready),
    .axi_ctrl_wdata        (wdata),
    .axi_ctrl_wstrb        (wstrb),
    .axi_ctrl_wvalid       (wvalid),
    .axi_ctrl_wready       (wready),
    .axi_ctrl_bresp        (bresp),
    .axi_ctrl_bvalid       (bvalid),
    .axi_ctrl_bready       (bready),
    .axi_ctrl_araddr       (araddr),
    .axi_ctrl_arvalid      (arvalid),
    .axi_ctrl_arready      (arready),
    .axi_ctrl_rdata        (rdata),
    .axi_ctrl_rresp        (rresp),
    .axi_ctrl_rvalid       (rvalid),
    .axi_ctrl_rready       (rready),
    .notify_valid          (notify_valid),
    .notify_ready          (notify_ready),
    .notify_data           (notify_data),
    .sq_rd_valid           (sq_rd_valid),
    .sq_rd_ready           (sq_rd_ready),
    .sq_rd_data            (sq_rd_data),
    .sq_wr_valid           (sq_wr_valid),
    .sq_wr_ready           (sq_wr_ready),
    .sq_wr_data            (sq_wr_data),
    .cq_rd_valid           (cq_rd_valid),
    .cq_rd_ready           (cq_rd_ready),
    .cq_rd_data            (cq_rd_data),
    .cq_wr_valid           (cq_wr_valid),
    .cq_wr_ready           (cq_wr_ready),
    .cq_wr_data            (cq_wr_data),
    .axis_host_recv_tvalid (recv_tvalid),
    .axis_host_recv_tready (recv_tready),
    .axis_host_recv_tdata  (recv_tdata),
    .axis_host_recv_tkeep  (recv_tkeep),
    .axis_host_recv_tlast  (recv_tlast),
    .axis_host_recv_tid    (recv_tid),
    .axis_host_send_tvalid (send_tvalid),
    .axis_host_send_tready (send_tready),
    .axis_host_send_tdata  (send_tdata),
    .axis_host_send_tkeep  (send_tkeep),
    .axis_host_send_tlast  (send_tlast),
    .axis_host_send_tid    (send_tid)
  );

  int tests = 0;
  int fails = 0;
  int sq_rd_cnt = 0, sq_wr_cnt = 0, notify_cnt = 0;

  req_t     exp_rd_q[$], exp_wr_q[$];
  irq_not_t exp_irq_q[$];
  wide_t    exp_beat_q[$];

  always @(posedge aclk) begin
    if (sq_rd_valid && sq_rd_ready) sq_rd_cnt <= sq_rd_cnt + 1;
    if (sq_wr_valid && sq_wr_ready) sq_wr_cnt <= sq_wr_cnt + 1;
    if (notify_valid && notify_ready) notify_cnt <= notify_cnt + 1;
  end

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [15:0] addr, input logic [63:0] data,
                            input logic [7:0] strb);
    int n;
    @(negedge aclk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    for (n = 0; n < 20 && !awready; n++) @(negedge aclk);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    for (n = 0; n < 20 && !bvalid; n++) begin @(posedge aclk); #1; end
    chk("bvalid_bresp", wide_t'({bvalid, bresp}), wide_t'(3'b100));
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic axil_read(input logic [15:0] addr, output logic [63:0] data);
    int n;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1;
    for (n = 0; n < 20 && !arready; n++) @(negedge aclk);
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    for (n = 0; n < 20 && !rvalid; n++) begin @(posedge aclk); #1; end
    chk("rvalid_rresp", wide_t'({rvalid, rresp}), wide_t'(3'b100));
    data = rdata;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic check_descriptors(input string tag);
    int n;
    req_t e;
    for (n = 0; n < 20 && !(sq_rd_valid && sq_wr_valid); n++) @(negedge aclk);
    chk({tag, "_sq_valids"}, wide_t'({sq_rd_valid, sq_wr_valid}), wide_t'(2'b11));
    e = exp_rd_q.pop_front();
    chk({tag, "_sq_rd_data"}, wide_t'(sq_rd_data), wide_t'(e));
    e = exp_wr_q.pop_front();
    chk({tag, "_sq_wr_data"}, wide_t'(sq_wr_data), wide_t'(e));
    @(negedge aclk);
    sq_rd_ready = 1'b1; sq_wr_ready = 1'b1;
    @(posedge aclk); #1;
    sq_rd_ready = 1'b0; sq_wr_ready = 1'b0;
    chk({tag, "_sq_drop"}, wide_t'({sq_rd_valid, sq_wr_valid}), wide_t'(2'b00));
  endtask

  initial begin
    logic [63:0]   rd;
    logic [DW-1:0] d, e;
    irq_not_t      ei;
    wide_t         eb;
    int            n;

    aresetn = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    notify_ready = 1'b0; sq_rd_ready = 1'b0; sq_wr_ready = 1'b0;
    cq_rd_valid = 1'b0; cq_wr_valid = 1'b0; cq_rd_data = '0; cq_wr_data = '0;
    recv_tvalid = 1'b1; recv_tdata = '1; recv_tkeep = '1; recv_tlast = 1'b1; recv_tid = '1;
    send_tready = 1'b1;

    // Reset state with upstream valids held high.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_axil_ready", wide_t'({awready, wready, arready}), wide_t'(3'b000));
    chk("rst_axil_resp_valid", wide_t'({bvalid, rvalid}), wide_t'(2'b00));
    chk("rst_valids", wide_t'({sq_rd_valid, sq_wr_valid, notify_valid, send_tvalid}),
        wide_t'(4'b0000));
    chk("rst_send_data", wide_t'(send_tdata[0]), wide_t'(0));
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; recv_tvalid = 1'b0;
    recv_tlast = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;

    axil_read(16'h08, rd);
    chk("status_after_reset", wide_t'(rd), wide_t'(0));

    // CSR access and byte strobes.
    axil_write(16'h38, 64'h5, 8'hFF);
    axil_read(16'h38, rd);
    chk("addc_readback", wide_t'(rd), wide_t'(64'h5));
    axil_read(16'h40, rd);
    chk("unmapped_read", wide_t'(rd), wide_t'(0));
    axil_write(16'h38, 64'hAABBCCDD, 8'h01);
    axil_read(16'h38, rd);
    chk("addc_wstrb", wide_t'(rd), wide_t'(64'hDD));
    axil_write(16'h38, 64'h1, 8'hFF);

    // Start with LEN == 0: error, no descriptors.
    axil_write(16'h00, 64'h1, 8'hFF);
    repeat (3) @(negedge aclk);
    chk("len0_no_sq", wide_t'({sq_rd_valid, sq_wr_valid, sq_rd_cnt[3:0]}), wide_t'(0));
    axil_read(16'h08, rd);
    chk("len0_err", wide_t'(rd), wide_t'(64'h4));
    axil_write(16'h00, 64'h2, 8'hFF);
    axil_read(16'h08, rd);
    chk("err_cleared", wide_t'(rd), wide_t'(0));

    // Program and launch a job.
    axil_write(16'h20, 64'h100, 8'hFF);
    axil_write(16'h28, 64'h3, 8'hFF);
    axil_write(16'h10, 64'h1000, 8'hFF);
    axil_write(16'h18, 64'h2000, 8'hFF);
    exp_rd_q.push_back('{vaddr: 48'h1000, len: 28'h100, strm: StrmHost, dest: 4'd0,
                         pid: 6'd3, last: 1'b1});
    exp_wr_q.push_back('{vaddr: 48'h2000, len: 28'h100, strm: StrmHost, dest: 4'd0,
                         pid: 6'd3, last: 1'b1});
    axil_write(16'h00, 64'h1, 8'hFF);
    check_descriptors("job1");
    axil_read(16'h08, rd);
    chk("status_busy", wide_t'(rd), wide_t'(64'h1));

    // Busy: a new PID applies to the next job only; a second start is ignored.
    axil_write(16'h28, 64'h7, 8'hFF);
    axil_write(16'h00, 64'h1, 8'hFF);
    repeat (3) @(negedge aclk);
    chk("busy_start_ignored", wide_t'({sq_rd_valid, sq_wr_valid}), wide_t'(2'b00));

    // Four beats through the datapath, one stall before beat 2.
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        @(negedge aclk);
        recv_tvalid = 1'b1; send_tready = 1'b0;
        #1;
        chk("stall_recv_tready", wide_t'(recv_tready), wide_t'(0));
      end
      @(negedge aclk);
      d = '1;
      if (k == 1) d[31:0] = 32'h12345678;
      for (int l = 0; l < 16; l++) e[l*32 +: 32] = d[l*32 +: 32] + 32'd1;
      exp_beat_q.push_back({(k == 3), e});
      recv_tvalid = 1'b1; recv_tdata[0] = d; recv_tlast = (k == 3);
      recv_tkeep[0] = 64'hFFFF_FFFF_FFFF_FFFF; recv_tid[0] = 6'd3; send_tready = 1'b1;
      #1;
      chk("beat_handshake", wide_t'({send_tvalid, recv_tready}), wide_t'(2'b11));
      eb = exp_beat_q.pop_front();
      chk("beat_last_data", wide_t'({send_tlast, send_tdata[0]}), eb);
      chk("beat_keep_id", wide_t'({send_tkeep[0], send_tid[0]}),
          wide_t'({64'hFFFF_FFFF_FFFF_FFFF, 6'd3}));
      @(posedge aclk);
    end
    @(negedge aclk);
    recv_tvalid = 1'b0; recv_tlast = 1'b0;
    axil_read(16'h30, rd);
    chk("beats_count", wide_t'(rd), wide_t'(64'd4));

    // Completions in wr-then-rd order, notify back-pressured for 5 cycles.
    exp_irq_q.push_back('{pid: 6'd3, value: 32'd4});
    @(negedge aclk);
    cq_wr_valid = 1'b1;
    @(posedge aclk); #1;
    cq_wr_valid = 1'b0;
    chk("no_notify_one_cq", wide_t'(notify_valid), wide_t'(0));
    @(negedge aclk);
    cq_rd_valid = 1'b1;
    @(posedge aclk); #1;
    cq_rd_valid = 1'b0;
    for (n = 0; n < 20 && !notify_valid; n++) begin @(posedge aclk); #1; end
    ei = exp_irq_q.pop_front();
    chk("notify_data", wide_t'({notify_valid, notify_data}), wide_t'({1'b1, ei}));
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      chk("notify_held", wide_t'(notify_valid), wide_t'(1));
    end
    @(negedge aclk);
    notify_ready = 1'b1;
    @(posedge aclk); #1;
    notify_ready = 1'b0;
    chk("notify_once", wide_t'({notify_valid, notify_cnt[3:0]}), wide_t'(5'b0_0001));
    axil_read(16'h08, rd);
    chk("status_done", wide_t'(rd), wide_t'(64'h2));
    chk("one_descriptor_each", wide_t'({sq_rd_cnt[7:0], sq_wr_cnt[7:0]}), wide_t'(16'h0101));

    // Second job picks up the PID written while busy, then reset during RUN.
    exp_rd_q.push_back('{vaddr: 48'h1000, len: 28'h100, strm: StrmHost, dest: 4'd0,
                         pid: 6'd7, last: 1'b1});
    exp_wr_q.push_back('{vaddr: 48'h2000, len: 28'h100, strm: StrmHost, dest: 4'd0,
                         pid: 6'd7, last: 1'b1});
    axil_write(16'h00, 64'h1, 8'hFF);
    check_descriptors("job2");
    @(negedge aclk);
    cq_rd_valid = 1'b1;
    @(posedge aclk); #1;
    cq_rd_valid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("midjob_rst_valids", wide_t'({sq_rd_valid, sq_wr_valid, notify_valid}),
        wide_t'(3'b000));
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    cq_wr_valid = 1'b1;
    @(posedge aclk); #1;
    cq_wr_valid = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    chk("midjob_no_notify", wide_t'({notify_valid, notify_cnt[3:0]}), wide_t'(5'b0_0001));
    axil_read(16'h08, rd);
    chk("midjob_status", wide_t'(rd), wide_t'(0));
    axil_read(16'h38, rd);
    chk("midjob_addc_reset", wide_t'(rd), wide_t'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
